// File: rtl/regfile_write_arbiter_if.sv
// Two valid/ready writeback requesters sharing one register-file write port.
interface regfile_write_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = 4
);
    logic                  in_req0_valid;
    logic [SEL_WIDTH-1:0]  in_req0_sel;
    logic [DATA_WIDTH-1:0] in_req0_data;
    logic                  out_req0_ready;

    logic                  in_req1_valid;
    logic [SEL_WIDTH-1:0]  in_req1_sel;
    logic [DATA_WIDTH-1:0] in_req1_data;
    logic                  out_req1_ready;

    logic                  out_write_en;
    logic [SEL_WIDTH-1:0]  out_write_sel;
    logic [DATA_WIDTH-1:0] out_write_data;
    logic [3:0]            out_starve_cnt;

    // Requester / environment side
    modport master (
        output in_req0_valid, in_req0_sel, in_req0_data,
        output in_req1_valid, in_req1_sel, in_req1_data,
        input  out_req0_ready, out_req1_ready,
        input  out_write_en, out_write_sel, out_write_data, out_starve_cnt
    );

    // Arbiter side
    modport slave (
        input  in_req0_valid, in_req0_sel, in_req0_data,
        input  in_req1_valid, in_req1_sel, in_req1_data,
        output out_req0_ready, out_req1_ready,
        output out_write_en, out_write_sel, out_write_data, out_starve_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: port 0 (pipeline) has priority, port 1
// (long-latency unit) is forced ahead after STARVE_LIMIT denied cycles.
// Grants are registered into a one-cycle output stage.
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SEL_WIDTH    = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    regfile_write_arbiter_if.slave bus_io
);
    localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

    logic [3:0]            starve_q, starve_d;
    logic                  wr_en_q, wr_en_d;
    logic [SEL_WIDTH-1:0]  wr_sel_q, wr_sel_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic force_p1;
    logic ready0, ready1;
    logic xfer0, xfer1;

    // Readies come from state and the other port's valid only; gated by reset
    // so nothing is accepted while rst_n is low.
    always_comb begin
        force_p1 = (starve_q >= StarveLimit);
        ready0   = rst_n & (~force_p1 | ~bus_io.in_req1_valid);
        ready1   = rst_n & (force_p1 | ~bus_io.in_req0_valid);
        xfer0    = bus_io.in_req0_valid & ready0;
        xfer1    = bus_io.in_req1_valid & ready1;
    end

    // Next-state: starvation counter and registered write stage.
    always_comb begin
        starve_d  = starve_q;
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_data_d = wr_data_q;

        if (!bus_io.in_req1_valid || xfer1) begin
            starve_d = 4'd0;
        end else if (starve_q != 4'hf) begin
            starve_d = starve_q + 4'd1;
        end

        // sel == 0 is accepted but discarded; sel/data keep their last value.
        if (xfer0 && (bus_io.in_req0_sel != '0)) begin
            wr_en_d   = 1'b1;
            wr_sel_d  = bus_io.in_req0_sel;
            wr_data_d = bus_io.in_req0_data;
        end else if (xfer1 && (bus_io.in_req1_sel != '0)) begin
            wr_en_d   = 1'b1;
            wr_sel_d  = bus_io.in_req1_sel;
            wr_data_d = bus_io.in_req1_data;
        end
    end

    // State registers; async reset drops any registered write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q  <= 4'd0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Output drive
    always_comb begin
        bus_io.out_req0_ready = ready0;
        bus_io.out_req1_ready = ready1;
        bus_io.out_write_en   = wr_en_q;
        bus_io.out_write_sel  = wr_sel_q;
        bus_io.out_write_data = wr_data_q;
        bus_io.out_starve_cnt = starve_q;
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus side models the arbitration rules and queues
// expected writes; a separate monitor pops and compares each DUT write.
module tb_regfile_write_arbiter;
    localparam int LIMIT = 4;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_WIDTH(32), .SEL_WIDTH(4)) bus ();

    regfile_write_arbiter #(
        .DATA_WIDTH  (32),
        .SEL_WIDTH   (4),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    int          total = 0;
    int          bad = 0;
    int          nwrites = 0;
    int          m_cnt = 0;
    logic        g0, g1;
    wr_t         q[$];
    logic [3:0]  last_sel = '0;
    logic [31:0] last_data = '0;
    logic [31:0] rf [16];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One cycle: decide the grant from the rules, compare DUT state, queue
    // the expected write, advance the wait counter, then pass the edge.
    task automatic step();
        logic f;
        wr_t  e;
        @(negedge clk);
        if (!rst_n) begin
            g0 = 1'b0;
            g1 = 1'b0;
            m_cnt = 0;
        end else begin
            chk("starve_cnt", bus.out_starve_cnt, m_cnt);
            f  = (m_cnt >= LIMIT);
            g0 = bus.in_req0_valid && !(bus.in_req1_valid && f);
            g1 = bus.in_req1_valid && !g0;
            chk("ready0", bus.out_req0_ready, !(bus.in_req1_valid && f));
            chk("ready1", bus.out_req1_ready, f || !bus.in_req0_valid);
            if (g0 && bus.in_req0_sel != 0) begin
                e.sel = bus.in_req0_sel;
                e.data = bus.in_req0_data;
                q.push_back(e);
            end
            if (g1 && bus.in_req1_sel != 0) begin
                e.sel = bus.in_req1_sel;
                e.data = bus.in_req1_data;
                q.push_back(e);
            end
            if (bus.in_req1_valid && !g1) m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
            else m_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Async reset in mid-cycle; everything must clear without a clock.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_write_en", bus.out_write_en, 0);
        chk("rst_write_sel", bus.out_write_sel, 0);
        chk("rst_write_data", bus.out_write_data, 0);
        chk("rst_starve", bus.out_starve_cnt, 0);
        chk("rst_ready0", bus.out_req0_ready, 0);
        chk("rst_ready1", bus.out_req1_ready, 0);
        q.delete();
        last_sel = '0;
        last_data = '0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: every presented write must match the oldest queued entry.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                if (bus.out_write_en) begin
                    if (q.size() == 0) begin
                        chk("spurious_write", bus.out_write_en, 0);
                    end else begin
                        e = q.pop_front();
                        chk("write_sel", bus.out_write_sel, e.sel);
                        chk("write_data", bus.out_write_data, e.data);
                    end
                    last_sel = bus.out_write_sel;
                    last_data = bus.out_write_data;
                    rf[bus.out_write_sel] = bus.out_write_data;
                    nwrites++;
                end else begin
                    chk("write_missing", q.size(), 0);
                    if (q.size() != 0) e = q.pop_front();
                    chk("hold_sel", bus.out_write_sel, last_sel);
                    chk("hold_data", bus.out_write_data, last_data);
                end
            end
        end
    end

    initial begin
        int n_before;
        int first_g1;
        int n0;
        int n1;
        for (int i = 0; i < 16; i++) rf[i] = '0;
        bus.in_req0_valid = 1'b0;
        bus.in_req0_sel = '0;
        bus.in_req0_data = '0;
        bus.in_req1_valid = 1'b0;
        bus.in_req1_sel = '0;
        bus.in_req1_data = '0;

        // Power-on reset
        #2;
        rst_n = 1'b0;
        #1;
        chk("por_write_en", bus.out_write_en, 0);
        chk("por_write_sel", bus.out_write_sel, 0);
        chk("por_write_data", bus.out_write_data, 0);
        chk("por_starve", bus.out_starve_cnt, 0);
        chk("por_ready0", bus.out_req0_ready, 0);
        chk("por_ready1", bus.out_req1_ready, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Single port-0 write, then idle
        bus.in_req0_valid = 1'b1;
        bus.in_req0_sel = 4'd3;
        bus.in_req0_data = 32'hDEADBEEF;
        step();
        bus.in_req0_valid = 1'b0;
        step();
        step();

        // Both valid continuously: port 1 must win on the fifth cycle
        first_g1 = 0;
        bus.in_req0_valid = 1'b1;
        bus.in_req0_sel = 4'd1;
        bus.in_req0_data = 32'h100;
        bus.in_req1_valid = 1'b1;
        bus.in_req1_sel = 4'd9;
        bus.in_req1_data = 32'h900;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (g1) begin
                first_g1 = k;
                break;
            end
            if (g0) begin
                bus.in_req0_sel = 4'(k + 1);
                bus.in_req0_data = 32'h100 + 32'(k);
            end
        end
        chk("starve_grant_cycle", first_g1, LIMIT + 1);
        bus.in_req0_valid = 1'b0;
        bus.in_req1_valid = 1'b0;
        step();

        // sel == 0 on port 1: accepted, no write
        n_before = nwrites;
        bus.in_req1_valid = 1'b1;
        bus.in_req1_sel = 4'd0;
        bus.in_req1_data = 32'h1234;
        step();
        bus.in_req1_valid = 1'b0;
        step();
        step();
        chk("sel0_no_write", nwrites, n_before);

        // Same register from both ports: port 0 first, port 1 last wins
        n0 = 0;
        n1 = 0;
        bus.in_req0_valid = 1'b1;
        bus.in_req0_sel = 4'd5;
        bus.in_req0_data = 32'hA;
        bus.in_req1_valid = 1'b1;
        bus.in_req1_sel = 4'd5;
        bus.in_req1_data = 32'hB;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (g0) begin
                n0 = k;
                bus.in_req0_valid = 1'b0;
            end
            if (g1) begin
                n1 = k;
                bus.in_req1_valid = 1'b0;
            end
            if (!bus.in_req0_valid && !bus.in_req1_valid) break;
        end
        step();
        step();
        chk("same_reg_order", (n0 != 0) && (n1 > n0), 1);
        chk("same_reg_r5", rf[5], 32'hB);

        // Port-0 stream of 8 back-to-back writes
        n_before = nwrites;
        bus.in_req0_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            bus.in_req0_sel = 4'(k);
            bus.in_req0_data = $urandom;
            step();
        end
        bus.in_req0_valid = 1'b0;
        step();
        step();
        chk("stream_writes", nwrites - n_before, 8);

        // Random traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step();
            if (g0 || !bus.in_req0_valid) begin
                bus.in_req0_valid = ($urandom_range(99) < 60);
                bus.in_req0_sel = 4'($urandom_range(15));
                bus.in_req0_data = $urandom;
            end
            if (g1 || !bus.in_req1_valid) begin
                bus.in_req1_valid = ($urandom_range(99) < 50);
                bus.in_req1_sel = 4'($urandom_range(15));
                bus.in_req1_data = $urandom;
            end
        end
        bus.in_req0_valid = 1'b0;
        bus.in_req1_valid = 1'b0;
        step();
        step();
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register data width.
REQ-002 Parameter SEL_WIDTH, default 4, register select width (16 registers).
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive denied cycles after which port 1 is forced ahead of port 0 (range 1..15).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active low.
REQ-007 in_req0_valid  in  1  pipeline writeback request.
REQ-008 in_req0_sel  in  SEL_WIDTH  destination register, port 0.
REQ-009 in_req0_data  in  DATA_WIDTH  write data, port 0.
REQ-010 out_req0_ready  out  1  port 0 accepted this cycle when valid and ready.
REQ-011 in_req1_valid / in_req1_sel / in_req1_data / out_req1_ready  same as port 0, for the long-latency unit (multiply/divide/load).
REQ-012 out_write_en  out  1  register-file write enable.
REQ-013 out_write_sel  out  SEL_WIDTH  register-file write select.
REQ-014 out_write_data  out  DATA_WIDTH  register-file write data.
REQ-015 out_starve_cnt  out  4  current port-1 wait count, debug.

Function
REQ-016 The block SHALL share the single register-file write port between two valid/ready requesters; at most one request SHALL be granted per cycle.
REQ-017 Transfer on port N SHALL occur exactly in cycles with in_reqN_valid && out_reqN_ready.
REQ-018 Ready rules (combinational from state and valids): force = (starve_cnt >= STARVE_LIMIT); out_req0_ready = !force || !in_req1_valid; out_req1_ready = force || !in_req0_valid.
REQ-019 When both ready and only one valid, that one SHALL be granted; when both valid, port 0 SHALL win unless force, then port 1 SHALL win.
REQ-020 Readies SHALL NOT depend on the requester's own valid; a requester may hold valid with stable sel/data until accepted.
REQ-021 starve_cnt: incremented (saturating at 15) each cycle in_req1_valid && !out_req1_ready; cleared on port-1 transfer or cycle with in_req1_valid low.
REQ-022 Output stage registered: a transfer at edge k SHALL drive out_write_en/sel/data during cycle k+1 (one-cycle latency), so the register file commits on edge k+1.
REQ-023 Cycle with no transfer SHALL produce out_write_en = 0 next cycle; out_write_sel/data SHALL hold their last value.
REQ-024 Requests with sel == 0 SHALL be accepted normally (ready, counter rules apply) but SHALL yield out_write_en = 0; data discarded.
REQ-025 Both ports targeting the same register in one cycle: only the granted one is written; the other remains pending and writes later (last-granted wins).
REQ-026 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
REQ-027 No reordering within a port; each accepted request produces exactly one output cycle.

Reset
REQ-028 On rst_n low, immediately (no clock): out_write_en = 0, out_write_sel = 0, out_write_data = 0, starve_cnt = 0.
REQ-029 During reset out_req0_ready and out_req1_ready SHALL be 0; no transfer occurs.
REQ-030 Reset asserted mid-stream SHALL drop any write registered but not yet on the output; first transfer allowed on first rising edge with rst_n high.

Verification
REQ-031 Port 0 only: valid, sel=3, data=0xDEADBEEF at edge k -> out_write_en=1, sel=3, data=0xDEADBEEF in cycle k+1, then out_write_en=0.
REQ-032 Both valid continuously, STARVE_LIMIT=4 -> port 0 granted 4 cycles, out_starve_cnt 1,2,3,4, port 1 granted on 5th cycle, counter back to 0.
REQ-033 sel=0 on port 1, data=0x1234 -> out_req1_ready=1, transfer, out_write_en stays 0.
REQ-034 Both valid, sel=5, data0=0xA, data1=0xB, starve_cnt=0 -> cycle k+1 writes 0xA, port 1 later writes 0xB; final r5=0xB.
REQ-035 Port 0 streaming 8 requests, sel 1..8 -> 8 consecutive out_write_en=1 cycles, sels 1..8 in order.
REQ-036 rst_n low during active stream -> outputs 0 and readies 0 asynchronously; after release, next request appears with one-cycle latency.
